// File: rtl/kadai4_pkg.sv
// Shared definitions for the kadai4 burst accumulator: default sizes,
// sum-width derivation and the accumulator state encoding.
package kadai4_pkg;

    localparam int DW_DEF        = 16;
    localparam int BURST_LEN_DEF = 8;

    // Width that holds BURST_LEN all-ones words without wrapping.
    function automatic int sum_width(input int dw, input int burst_len);
        return dw + $clog2(burst_len);
    endfunction

    typedef enum logic {
        ACC_IDLE,
        ACC_RUN
    } acc_state_t;

endpackage

// File: rtl/kadai4_burst_acc.sv
// kadai4_burst_acc: reduces each burst of BURST_LEN words to a sum and an
// unsigned maximum, holding the result in a one-deep slot until acknowledged.
// Optional feature macro: KADAI4_BURST_ACC_AVG_EN adds the res_avg output.
module kadai4_burst_acc
    import kadai4_pkg::*;
#(
    parameter int  DW        = DW_DEF,
    parameter int  BURST_LEN = BURST_LEN_DEF,
    localparam int SUM_W     = sum_width(DW, BURST_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic [DW-1:0]    din,
    input  logic             din_valid,
    output logic             busy,
    output logic [SUM_W-1:0] res_sum,
    output logic [DW-1:0]    res_max,
    output logic             res_valid,
    input  logic             res_ack,
    output logic             ovf
`ifdef KADAI4_BURST_ACC_AVG_EN
    ,
    output logic [DW-1:0]    res_avg
`endif
);

    localparam int             CW   = $clog2(BURST_LEN);
    localparam logic [CW-1:0]  LAST = CW'(BURST_LEN - 1);

    acc_state_t       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done;
    logic [SUM_W-1:0] sum_q, sum_next;
    logic [DW-1:0]    max_q, max_next;

    // State and word-count register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ACC_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state, count and burst-completion decode; halt wins over din_valid
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done    = 1'b0;
        if (halt) begin
            state_d = ACC_IDLE;
            count_d = '0;
        end else if (din_valid) begin
            case (state_q)
                ACC_IDLE: begin
                    state_d = ACC_RUN;
                    count_d = CW'(1);
                end
                ACC_RUN: begin
                    if (count_q == LAST) begin
                        done    = 1'b1;
                        state_d = ACC_IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ACC_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Sum adder: first word of a burst loads, later words add
    always_comb begin
        sum_next = SUM_W'(din);
        if (state_q == ACC_RUN) begin
            sum_next = sum_q + SUM_W'(din);
        end
    end

    // Unsigned max compare: first word of a burst loads, later words compete
    always_comb begin
        max_next = din;
        if ((state_q == ACC_RUN) && (din <= max_q)) begin
            max_next = max_q;
        end
    end

    // Working sum/max registers
    always_ff @(posedge clk) begin
        if (!rst || halt) begin
            sum_q <= '0;
            max_q <= '0;
        end else if (din_valid) begin
            sum_q <= sum_next;
            max_q <= max_next;
        end
    end

    // Result slot: load on completion when empty or being acked, else flag overflow
    always_ff @(posedge clk) begin
        if (!rst || halt) begin
            res_sum   <= '0;
            res_max   <= '0;
            res_valid <= 1'b0;
            ovf       <= 1'b0;
`ifdef KADAI4_BURST_ACC_AVG_EN
            res_avg   <= '0;
`endif
        end else if (done) begin
            if (!res_valid || res_ack) begin
                res_sum   <= sum_next;
                res_max   <= max_next;
                res_valid <= 1'b1;
`ifdef KADAI4_BURST_ACC_AVG_EN
                res_avg   <= sum_next[SUM_W-1:CW];
`endif
            end else begin
                ovf <= 1'b1;
            end
        end else if (res_ack) begin
            res_valid <= 1'b0;
        end
    end

    assign busy = (state_q == ACC_RUN);

endmodule
